// File: rtl/player_motion_if.sv
// player_motion_if: bundles the player motion engine's tick/key/collision inputs
// and its position/scroll/status outputs.
//   master : drives vtick, htick, keycode, coll, restart, bias; observes outputs
//   slave  : the motion engine; drives ver, hor, coll_rst, map_move, map_move_vld, dead, state
interface player_motion_if #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned BIAS_W = 6
);
    logic              vtick;
    logic              htick;
    logic [5:0]        keycode;
    logic              coll;
    logic              restart;
    logic [BIAS_W-1:0] bias;
    logic [ROWS-1:0]   ver;
    logic [COLS-1:0]   hor;
    logic              coll_rst;
    logic [BIAS_W-1:0] map_move;
    logic              map_move_vld;
    logic              dead;
    logic [1:0]        state;

    modport master (
        output vtick, htick, keycode, coll, restart, bias,
        input  ver, hor, coll_rst, map_move, map_move_vld, dead, state
    );

    modport slave (
        input  vtick, htick, keycode, coll, restart, bias,
        output ver, hor, coll_rst, map_move, map_move_vld, dead, state
    );
endinterface

// File: rtl/player_motion.sv
// player_motion: single-clock doodle-jump player mover. Tracks one-hot vertical
// and horizontal positions, runs the FALL/RISE/DEAD jump state machine and
// requests a map scroll on every platform landing.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   bus   - player_motion_if.slave (ticks, keys, collision, bias in;
//           ver/hor position, coll_rst, map_move(+vld), dead, state out)
module player_motion #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned JUMP_H    = 3,
    parameter int unsigned START_ROW = 1,
    parameter int unsigned BIAS_W    = 6,
    parameter bit          WRAP      = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    player_motion_if.slave  bus
);

    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CNT_W = $clog2(JUMP_H + 1);

    localparam logic [ROWS-1:0]   VER_RST = ROWS'(1) << START_ROW;
    localparam logic [COLS-1:0]   HOR_RST = COLS'(1) << (COLS / 2);
    localparam logic [BIAS_W-1:0] MM_RST  = BIAS_W'(ROWS);
    localparam logic [BIAS_W-1:0] MM_BOT  = BIAS_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  JUMP_C  = CNT_W'(JUMP_H);

    typedef enum logic [1:0] {
        FALL = 2'b00,
        RISE = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ROWS-1:0]   ver_q, ver_d;
    logic [COLS-1:0]   hor_q, hor_d;
    logic [BIAS_W-1:0] mm_q, mm_d;
    logic              crst_q, crst_d;
    logic              vld_q, vld_d;
    logic              dead_q, dead_d;

    logic [IDX_W-1:0]  row_idx;
    logic [ROWS-1:0]   ver_up;
    logic [ROWS-1:0]   ver_down;
    logic [COLS-1:0]   hor_left;
    logic [COLS-1:0]   hor_right;
    logic [BIAS_W-1:0] mm_land;
    logic              key_left;
    logic              key_right;
    logic              unused_keys;

    // Only keycode[2:1] carry direction information.
    assign key_left    = ~bus.keycode[1] & bus.keycode[2];
    assign key_right   =  bus.keycode[1] & bus.keycode[2];
    assign unused_keys = ^{bus.keycode[5:3], bus.keycode[0]};

    // Row index of the one-hot vertical position.
    always_comb begin
        row_idx = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (ver_q[i]) begin
                row_idx = IDX_W'(i);
            end
        end
    end

    // Up saturates at the top row; down off the bottom row leaves ver empty.
    assign ver_up   = ver_q[0] ? ver_q : (ver_q >> 1);
    assign ver_down = ver_q << 1;

    // Rotation covers both the interior shift and the wrap case; saturation blocks the edge.
    assign hor_left  = (!WRAP && hor_q[COLS-1]) ? hor_q : {hor_q[COLS-2:0], hor_q[COLS-1]};
    assign hor_right = (!WRAP && hor_q[0])      ? hor_q : {hor_q[0], hor_q[COLS-1:1]};

    // Scroll amount is the landing height above the bottom row, offset by the map bias.
    assign mm_land = bus.bias + (MM_BOT - BIAS_W'(row_idx));

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FALL;
            count_q <= '0;
            ver_q   <= VER_RST;
            hor_q   <= HOR_RST;
            mm_q    <= MM_RST;
            crst_q  <= 1'b0;
            vld_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ver_q   <= ver_d;
            hor_q   <= hor_d;
            mm_q    <= mm_d;
            crst_q  <= crst_d;
            vld_q   <= vld_d;
            dead_q  <= dead_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ver_d   = ver_q;
        hor_d   = hor_q;
        mm_d    = mm_q;
        crst_d  = 1'b0;
        vld_d   = 1'b0;
        dead_d  = dead_q;

        case (state_q)
            FALL: begin
                if (bus.vtick) begin
                    if (bus.coll) begin
                        mm_d    = mm_land;
                        vld_d   = 1'b1;
                        crst_d  = 1'b1;
                        ver_d   = ver_up;
                        count_d = CNT_W'(1);
                        state_d = RISE;
                    end else begin
                        ver_d = ver_down;
                        if (ver_q[ROWS-1]) begin
                            state_d = DEAD;
                            mm_d    = '0;
                            dead_d  = 1'b1;
                        end
                    end
                end
            end
            RISE: begin
                // Collisions are ignored while climbing.
                if (bus.vtick) begin
                    if (count_q < JUMP_C) begin
                        ver_d   = ver_up;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        ver_d   = ver_down;
                        state_d = FALL;
                    end
                end
            end
            DEAD: begin
                if (bus.restart) begin
                    state_d = FALL;
                    count_d = '0;
                    ver_d   = VER_RST;
                    hor_d   = HOR_RST;
                    mm_d    = MM_RST;
                    dead_d  = 1'b0;
                end
            end
            default: begin
                state_d = FALL;
            end
        endcase

        // Horizontal axis is independent of the vertical step in the same cycle.
        if (state_q != DEAD && bus.htick) begin
            if (key_left) begin
                hor_d = hor_left;
            end else if (key_right) begin
                hor_d = hor_right;
            end
        end
    end

    assign bus.ver          = ver_q;
    assign bus.hor          = hor_q;
    assign bus.coll_rst     = crst_q;
    assign bus.map_move     = mm_q;
    assign bus.map_move_vld = vld_q;
    assign bus.dead         = dead_q;
    assign bus.state        = state_q;

endmodule
